// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster controller.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int COORD_W = 11;  // coordinate width on the ports
  localparam int CNT_W   = 12;  // raster counter / cursor compare width

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Full line or frame length in pixel clocks / lines.
  function automatic int vga_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  // Cursor position snapshot taken once per frame.
  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cursor_pos_t;

  // Per-pixel control flags that travel alongside the frame-buffer read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic hit;
  } vga_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay with asynchronous reset to RST_VAL.
// DEPTH 0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unusedClkRst;
      assign unusedClkRst = iCLK ^ iRST_N;
      assign oData = iData;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];
      // Shift register, cleared to the idle value on reset.
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
        end else begin
          pipe[0] <= iData;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign oData = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_display_ctrl.sv
// Parametrised VGA raster controller: sync/blank generation, linear
// frame-buffer read requests, and re-alignment of returned pixel data
// with sync so every VGA pin changes on the same edge.
// Optional cursor crosshair overlay: define VGA_CURSOR_EN.
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int CUR_HALF = 1
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  input  logic [COORD_W-1:0] iCursor_X,
  input  logic [COORD_W-1:0] iCursor_Y,
  input  logic [COLOR_W-1:0] iCursor_R,
  input  logic [COLOR_W-1:0] iCursor_G,
  input  logic [COLOR_W-1:0] iCursor_B,
  input  logic               iCursor_EN,
  output logic               oReq,
  output logic [ADDR_W-1:0]  oAddress,
  output logic [COORD_W-1:0] oCoord_X,
  output logic [COORD_W-1:0] oCoord_Y,
  output logic               oFrame_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_DE
);

  localparam int H_TOTAL = vga_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACT, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_ACT + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

  localparam vga_flags_t FLAGS_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, hit: 1'b0};

  // ---------------- stage 0: raster counters ----------------
  logic [CNT_W-1:0] hCnt, vCnt;
  logic             active0, frameStart0, hit0;
  vga_flags_t       flags0, flags1, flagsD;

  // Horizontal counter wraps each line; vertical advances on the wrap.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_LAST_C) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST_C) ? '0 : vCnt + CNT_W'(1);
    end else begin
      hCnt <= hCnt + CNT_W'(1);
    end
  end

  assign active0     = (hCnt < H_ACT_C) && (vCnt < V_ACT_C);
  assign frameStart0 = (hCnt == '0) && (vCnt == '0);

`ifdef VGA_CURSOR_EN
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CUR_HALF);

  cursor_pos_t        curLat, curEff;
  logic [COLOR_W-1:0] curR, curG, curB;
  logic [CNT_W-1:0]   cx, cy;
  logic               hitX, hitY;

  // Snapshot cursor once per frame so mid-frame moves cannot tear.
  // Colour is used RD_LAT+2 cycles later; vertical blanking hides that gap.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      curLat <= '0;
      curR   <= '0;
      curG   <= '0;
      curB   <= '0;
    end else if (frameStart0) begin
      curLat <= '{en: iCursor_EN, x: iCursor_X, y: iCursor_Y};
      curR   <= iCursor_R;
      curG   <= iCursor_G;
      curB   <= iCursor_B;
    end
  end

  // Pixel (0,0) must already see the new frame's snapshot.
  always_comb begin
    curEff = curLat;
    if (frameStart0) curEff = '{en: iCursor_EN, x: iCursor_X, y: iCursor_Y};
  end

  // Distance test rearranged so nothing underflows and edges never wrap.
  assign cx   = {1'b0, curEff.x};
  assign cy   = {1'b0, curEff.y};
  assign hitX = (hCnt + HALF_C >= cx) && (hCnt <= cx + HALF_C);
  assign hitY = (vCnt + HALF_C >= cy) && (vCnt <= cy + HALF_C);
  assign hit0 = curEff.en && (hitX || hitY);
`else
  logic unusedCursor;
  assign unusedCursor = ^{iCursor_X, iCursor_Y, iCursor_R, iCursor_G, iCursor_B,
                          iCursor_EN, flagsD.hit};
  assign hit0 = 1'b0;
`endif

  // Sync windows follow active area and front porch.
  always_comb begin
    flags0     = FLAGS_IDLE;
    flags0.hs  = ((hCnt >= H_SS_C) && (hCnt < H_SE_C)) ? SYNC_POL : ~SYNC_POL;
    flags0.vs  = ((vCnt >= V_SS_C) && (vCnt < V_SE_C)) ? SYNC_POL : ~SYNC_POL;
    flags0.de  = active0;
    flags0.hit = hit0;
  end

  // ---------------- stage 1: request and flag register ----------------
  // Address is a running counter rather than Y*H_ACT+X.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oReq         <= 1'b0;
      oFrame_Start <= 1'b0;
      oCoord_X     <= '0;
      oCoord_Y     <= '0;
      oAddress     <= '0;
      flags1       <= FLAGS_IDLE;
    end else begin
      oReq         <= active0;
      oFrame_Start <= frameStart0;
      flags1       <= flags0;
      if (active0) begin
        oCoord_X <= hCnt[COORD_W-1:0];
        oCoord_Y <= vCnt[COORD_W-1:0];
      end
      if (frameStart0)  oAddress <= '0;
      else if (active0) oAddress <= oAddress + ADDR_W'(1);
    end
  end

  // Hold flags while the frame-buffer read is in flight.
  vga_delay_line #(
    .WIDTH   ($bits(vga_flags_t)),
    .DEPTH   (RD_LAT),
    .RST_VAL (FLAGS_IDLE)
  ) u_dly (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iData  (flags1),
    .oData  (flagsD)
  );

  // ---------------- output stage ----------------
  logic [COLOR_W-1:0] pixR, pixG, pixB;

  // Choose overlay or returned pixel colour.
  always_comb begin
    pixR = iRed;
    pixG = iGreen;
    pixB = iBlue;
`ifdef VGA_CURSOR_EN
    if (flagsD.hit) begin
      pixR = curR;
      pixG = curG;
      pixB = curB;
    end
`endif
  end

  // All pins update together; colour is blanked outside the active area.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_DE     <= 1'b0;
      oVGA_H_SYNC <= ~SYNC_POL;
      oVGA_V_SYNC <= ~SYNC_POL;
    end else begin
      oVGA_DE     <= flagsD.de;
      oVGA_H_SYNC <= flagsD.hs;
      oVGA_V_SYNC <= flagsD.vs;
      oVGA_R      <= flagsD.de ? pixR : '0;
      oVGA_G      <= flagsD.de ? pixG : '0;
      oVGA_B      <= flagsD.de ? pixB : '0;
    end
  end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Randomized bench for vga_display_ctrl on a reduced raster (24x13).
// The reference model derives every expected pin from the elapsed cycle
// count since reset release using the raster timing rules directly.
module tb_vga_display_ctrl;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int LAT = 3, CW = 4, AW = 7, HALF = 1;

  logic          iCLK = 1'b0, iRST_N = 1'b0;
  logic [CW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic [10:0]   iCursor_X = '0, iCursor_Y = '0;
  logic [CW-1:0] iCursor_R = '0, iCursor_G = '0, iCursor_B = '0;
  logic          iCursor_EN = 1'b0;
  logic          oReq, oFrame_Start, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_DE;
  logic [AW-1:0] oAddress;
  logic [10:0]   oCoord_X, oCoord_Y;
  logic [CW-1:0] oVGA_R, oVGA_G, oVGA_B;

  vga_display_ctrl #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COLOR_W(CW), .ADDR_W(AW), .RD_LAT(LAT), .CUR_HALF(HALF)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iCursor_X(iCursor_X), .iCursor_Y(iCursor_Y),
    .iCursor_R(iCursor_R), .iCursor_G(iCursor_G), .iCursor_B(iCursor_B),
    .iCursor_EN(iCursor_EN),
    .oReq(oReq), .oAddress(oAddress), .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
    .oFrame_Start(oFrame_Start),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_DE(oVGA_DE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic req; logic fs; logic [10:0] x; logic [10:0] y; logic [AW-1:0] a;
  } s1_t;
  typedef struct packed {
    logic hs; logic vs; logic de; logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b;
  } pin_t;

  int nCmp = 0, nBad = 0;
  int e = 0;                         // rising edges since reset release
  logic [3*CW-1:0] src [VA][HA];     // frame-buffer contents
  int hX [64], hY [64], hEn [64];    // cursor state seen at each frame start
  logic [3*CW-1:0] hC [64];

  function automatic int adiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic s1_t model_s1(int ec);
    s1_t s; int r, pos, x, y;
    s = '0;
    r = ec - 1;
    if (r >= 0) begin
      pos = r % FR; x = pos % HT; y = pos / HT;
      s.req = (x < HA) && (y < VA);
      s.fs  = (pos == 0);
      if (y < VA) begin s.x = 11'((x < HA) ? x : HA - 1); s.y = 11'(y); end
      else        begin s.x = 11'(HA - 1); s.y = 11'(VA - 1); end
      s.a = AW'(int'(s.y) * HA + int'(s.x));
    end
    return s;
  endfunction

  function automatic pin_t model_pin(int ec);
    pin_t p; int q, pos, f, x, y; logic hit;
    p = '{hs: 1'b1, vs: 1'b1, de: 1'b0, r: '0, g: '0, b: '0};
    q = ec - 2 - LAT;
    if (q >= 0) begin
      pos = q % FR; f = (q / FR) % 64; x = pos % HT; y = pos / HT;
      p.de = (x < HA) && (y < VA);
      p.hs = !((x >= HA + HF) && (x < HA + HF + HS));
      p.vs = !((y >= VA + VF) && (y < VA + VF + VS));
      hit = 1'b0;
`ifdef VGA_CURSOR_EN
      hit = (hEn[f] != 0) && ((adiff(x, hX[f]) <= HALF) || (adiff(y, hY[f]) <= HALF));
`endif
      if (p.de) {p.r, p.g, p.b} = hit ? hC[f] : src[y][x];
    end
    return p;
  endfunction

  // Behaves as the frame-buffer source for cycle e, then advances a clock.
  task automatic step();
    int p, pos, x, y;
    p = e - 1 - LAT;
    {iRed, iGreen, iBlue} = 12'($urandom);
    if (p >= 0) begin
      pos = p % FR; x = pos % HT; y = pos / HT;
      if (x < HA && y < VA) {iRed, iGreen, iBlue} = src[y][x];
    end
    if (e % FR == 0) begin
      hX[(e / FR) % 64]  = int'(iCursor_X);
      hY[(e / FR) % 64]  = int'(iCursor_Y);
      hEn[(e / FR) % 64] = int'(iCursor_EN);
      hC[(e / FR) % 64]  = {iCursor_R, iCursor_G, iCursor_B};
    end
    @(posedge iCLK);
    e++;
    @(negedge iCLK);
  endtask

  task automatic pick_cursor();
    iCursor_X  = 11'($urandom_range(0, HA + 1));
    iCursor_Y  = 11'($urandom_range(0, VA + 1));
    iCursor_EN = ($urandom_range(0, 3) != 0);
    {iCursor_R, iCursor_G, iCursor_B} = 12'($urandom);
  endtask

  task automatic test_reset();
    logic [63:0] got, want;
    iRST_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {iRed, iGreen, iBlue} = 12'($urandom);
      pick_cursor();
      @(negedge iCLK);
      got  = 64'({oReq, oFrame_Start, oAddress, oCoord_X, oCoord_Y, oVGA_R, oVGA_G, oVGA_B,
                  oVGA_DE, oVGA_H_SYNC, oVGA_V_SYNC});
      want = 64'(3'b011);
      nCmp++;
      if (got !== want) begin
        nBad++;
        $display("FAIL reset_state: got %h want %h", got, want);
      end
    end
    iRST_N = 1'b1;
    e = 0;
  endtask

  task automatic test_raster(int cycles, bit moveCursor);
    s1_t es, gs; pin_t ep, gp;
    for (int i = 0; i < cycles; i++) begin
      es = model_s1(e); ep = model_pin(e);
      gs = '{req: oReq, fs: oFrame_Start, x: oCoord_X, y: oCoord_Y, a: oAddress};
      gp = '{hs: oVGA_H_SYNC, vs: oVGA_V_SYNC, de: oVGA_DE, r: oVGA_R, g: oVGA_G, b: oVGA_B};
      nCmp++;
      if (gs !== es) begin
        nBad++;
        if (nBad < 30) $display("FAIL stage1 cyc %0d: got %h want %h", e, gs, es);
      end
      nCmp++;
      if (gp !== ep) begin
        nBad++;
        if (nBad < 30) $display("FAIL pins cyc %0d: got %h want %h", e, gp, ep);
      end
      if (moveCursor && $urandom_range(0, 60) == 0) pick_cursor();
      step();
    end
  endtask

  task automatic test_cursor_corners();
    iCursor_X = '0; iCursor_Y = '0; iCursor_EN = 1'b1;
    {iCursor_R, iCursor_G, iCursor_B} = 12'hF00;
    test_raster(2 * FR, 1'b0);
    iCursor_X = 11'(HA - 1); iCursor_Y = 11'(VA - 1);
    test_raster(FR, 1'b0);
  endtask

  // Cursor moved mid-frame: current frame keeps the old column.
  task automatic test_tear_free();
    int guard = 0;
    iCursor_X = 11'd3; iCursor_Y = 11'(VA + 1); iCursor_EN = 1'b1;
    {iCursor_R, iCursor_G, iCursor_B} = 12'h0F0;
    while ((e % FR) != 0 && guard < FR) begin test_raster(1, 1'b0); guard++; end
    test_raster(4 * HT, 1'b0);
    iCursor_X = 11'd10;
    test_raster(FR + 4 * HT, 1'b0);
  endtask

  task automatic test_frame_counts();
    int reqN = 0, hsLow = 0, vsLow = 0, fsN = 0;
    for (int i = 0; i < FR; i++) begin
      reqN  += int'(oReq);
      hsLow += int'(!oVGA_H_SYNC);
      vsLow += int'(!oVGA_V_SYNC);
      fsN   += int'(oFrame_Start);
      step();
    end
    nCmp++; if (reqN != HA * VA)  begin nBad++; $display("FAIL req_count: got %0d want %0d", reqN, HA * VA); end
    nCmp++; if (hsLow != HS * VT) begin nBad++; $display("FAIL hsync_low: got %0d want %0d", hsLow, HS * VT); end
    nCmp++; if (vsLow != VS * HT) begin nBad++; $display("FAIL vsync_low: got %0d want %0d", vsLow, VS * HT); end
    nCmp++; if (fsN != 1)         begin nBad++; $display("FAIL frame_start_count: got %0d want 1", fsN); end
  endtask

  task automatic test_mid_reset();
    logic [63:0] got, want;
    int guard = 0;
    while ((e % FR) != (3 * HT + 7) && guard < 2 * FR) begin step(); guard++; end
    iRST_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) #1; else @(negedge iCLK);
      got  = 64'({oReq, oFrame_Start, oAddress, oCoord_X, oCoord_Y, oVGA_R, oVGA_G, oVGA_B,
                  oVGA_DE, oVGA_H_SYNC, oVGA_V_SYNC});
      want = 64'(3'b011);
      nCmp++;
      if (got !== want) begin
        nBad++;
        $display("FAIL mid_reset_hold %0d: got %h want %h", i, got, want);
      end
    end
    iRST_N = 1'b1;
    e = 0;
    step();
    nCmp++;
    if ({oReq, oFrame_Start, oAddress} !== {1'b1, 1'b1, AW'(0)}) begin
      nBad++;
      $display("FAIL first_req_after_reset: got %b%b %0d want 1 1 0", oReq, oFrame_Start, oAddress);
    end
    test_raster(FR + 40, 1'b1);
  endtask

  initial begin
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) src[y][x] = 12'($urandom);
    test_reset();
    test_raster(2 * FR + 50, 1'b1);
    test_cursor_corners();
    test_tear_free();
    test_frame_counts();
    test_mid_reset();
    test_frame_counts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
